user_command_issuer: RTL and testbench
======================================

# user_command_issuer

Host-side initiator for the `!`-framed serial command protocol: accepts one read, write or version request, serializes the command frame onto a UART transmitter, and paces write payload. It checks the echoed command byte and returns read/version payload or the write acknowledgement. It sits between a local requester (test driver or board-to-board link controller) and a UART core, and talks to the FPGA-side command parser over that link.

## Interface
- `VERSION_LEN`, 8: payload bytes returned for a `V` request.
- `WR_GAP_CYCLES`, 16: minimum clocks between write payload byte strobes; the peer has no write flow control.
- `TIMEOUT_CYCLES`, 1_000_000: maximum clocks spent waiting for any expected rx byte.
- `clk` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; a request is accepted when `req_valid && req_ready`.
- `req_cmd` in 8: `"R"`, `"W"` or `"V"`; any other value is sent as-is.
- `req_len` in 24: payload byte count for R/W.
- `req_addr` in 32: start address for R/W.
- `wr_data` in 8: write payload byte.
- `wr_valid` in 1: payload byte present.
- `wr_ready` out 1: payload byte consumed this cycle.
- `rd_data` out 8: returned payload byte.
- `rd_valid` out 1: one-cycle pulse per returned byte.
- `done` out 1: one-cycle pulse at transaction end, success or failure.
- `error` out 2: 0 none, 1 echo mismatch, 2 bad write ack, 3 timeout; held until next accept.
- `uart_txd` out 8: tx byte.
- `uart_txd_strobe` out 1: one-cycle tx pulse.
- `uart_txd_ready` in 1: UART can take a byte.
- `uart_rxd` in 8: rx byte.
- `uart_rxd_strobe` in 1: rx byte valid, one cycle.

## Operation
- States: IDLE, HDR, CMD, ECHO, LEN2, LEN1, LEN0, ADDR3..ADDR0, WDATA, WACK, RDATA, FIN.
- IDLE: on accept, latch cmd/len/addr, clear `error`, go to HDR.
- HDR sends `"!"`, then CMD sends `req_cmd`. The machine then waits in ECHO for the first rx byte.
- ECHO: a byte equal to cmd goes to LEN2 for R/W, or to RDATA with `VERSION_LEN` bytes remaining for V. Any other byte sets `error=1` and goes to FIN. This covers `"?"` for an unknown command.
- LEN2..LEN0 send `req_len` MSB first, then ADDR3..ADDR0 send `req_addr` MSB first. After ADDR0, R goes to RDATA and W goes to WDATA, each with `req_len` remaining.
- RDATA: each rx byte gives `rd_valid` and decrements remaining. At 0, go to FIN.
- WDATA: when remaining is 0, go to WACK. Otherwise, when `wr_valid`, tx slot free and gap elapsed, send `wr_data`, pulse `wr_ready` and decrement remaining.
- WACK: rx `"W"` goes to FIN. Any other byte sets `error=2` and goes to FIN.
- FIN: pulse `done`, return to IDLE.
- Rx bytes in IDLE or in tx-only states are ignored.
- Remaining count is 24 bits and never wraps, because the decrement is gated on nonzero.
- `req_len=0`: R completes directly after ADDR0. W goes straight to WACK.

## Timing
- Reset values:
  - `uart_txd_strobe=0`, `uart_txd=0`, `rd_valid=0`, `wr_ready=0`, `done=0`, `error=0`.
  - `req_ready=1`, state IDLE, counters 0.
- Tx rule: `uart_txd_strobe` may assert only when `uart_txd_ready` is high and the strobe was low the previous cycle, so there are at least 2 clocks per tx byte.
- Frame bytes are sent back-to-back under that rule. The first tx strobe follows the accept by one cycle.
- Write gap: the counter restarts on each payload strobe. The next payload strobe needs at least `WR_GAP_CYCLES` elapsed.
- `rd_valid` follows the rx strobe by exactly 1 cycle, with `rd_data` registered from `uart_rxd`.
- `done` asserts 1 cycle after the terminating rx byte or the error event. `req_ready` rises in the cycle after `done`.
- Reset mid-transaction: all outputs return to reset values immediately. No partial frame is completed, and the peer recovers through its own error path.

## Configuration
- `USER_CMD_TIMEOUT_EN` defined:
  - In ECHO, RDATA and WACK, a counter runs and restarts on every rx strobe.
  - Reaching `TIMEOUT_CYCLES` sets `error=3` and goes to FIN.
- Undefined: no counter; those states wait indefinitely, and `error` never takes value 3.

## Structure
- Package `user_cmd_pkg`:
  - Byte constants: `CMD_HDR "!"`, `CMD_RD "R"`, `CMD_WR "W"`, `CMD_VERSION "V"`, `RSP_INVALID "?"`.
  - Error code constants and the state enum.
- Sub-module `user_cmd_tx_pacer`: single-byte tx slot enforcing the strobe rule and the write-gap counter, with a `free` output to the FSM.

## Test plan
- V request: tx `21 56`; feed `56` then 8×`31` -> 8 `rd_valid` with `31`, one `done`, `error=0`.
- R len=3 addr=0x00001000:
  - tx `21 52 00 00 03 00 00 10 00`.
  - Feed `52 AA BB CC` -> `rd_data` AA, BB, CC, then `done`.
- W len=2, data `11 22`:
  - tx frame, then `11 22` spaced ≥16 clocks.
  - Feed `57` -> `done`, `error=0`. Holding `wr_valid` high still gives exactly 2 `wr_ready` pulses.
- cmd `"X"`: feed `3F` after CMD -> `error=1`, `done`, no len/addr bytes sent.
- Timeout (`USER_CMD_TIMEOUT_EN`, `TIMEOUT_CYCLES=100`):
  - R len=4, feed echo + 1 byte, then silence -> `error=3` 100 clocks after the last rx.
  - Without the macro, the same stimulus stays in RDATA.
- Reset mid-frame: assert `reset_n=0` during ADDR1 -> strobe low immediately; after release `req_ready=1`, and a new V request completes normally.

Source files
------------

// File: rtl/user_cmd_pkg.sv
// Shared constants and state encoding for the host-side command issuer.
package user_cmd_pkg;

    localparam logic [7:0] CMD_HDR     = 8'h21;
    localparam logic [7:0] CMD_RD      = 8'h52;
    localparam logic [7:0] CMD_WR      = 8'h57;
    localparam logic [7:0] CMD_VERSION = 8'h56;
    localparam logic [7:0] RSP_INVALID = 8'h3F;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ECHO    = 2'd1;
    localparam logic [1:0] ERR_WACK    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_CMD,
        ST_ECHO,
        ST_LEN2,
        ST_LEN1,
        ST_LEN0,
        ST_ADDR3,
        ST_ADDR2,
        ST_ADDR1,
        ST_ADDR0,
        ST_WDATA,
        ST_WACK,
        ST_RDATA,
        ST_FIN
    } state_t;

endpackage

// File: rtl/user_cmd_tx_pacer.sv
// Single-byte UART tx slot: one strobe per free slot, plus write-payload gap timer.
module user_cmd_tx_pacer #(
    parameter int unsigned WR_GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       send,
    input  logic       payload,
    input  logic [7:0] data,
    input  logic       uart_txd_ready,
    output logic [7:0] uart_txd,
    output logic       uart_txd_strobe,
    output logic       free,
    output logic       gap_ok_c
);

    localparam int unsigned GW = $clog2(WR_GAP_CYCLES) + 1;
    localparam logic [GW-1:0] GAP_MAX = GW'(WR_GAP_CYCLES - 1);

    logic [GW-1:0] gap_cnt;

    // A byte may go out only when the UART is ready and no strobe was issued last cycle.
    assign free     = uart_txd_ready && !uart_txd_strobe;
    assign gap_ok_c = (gap_cnt >= GAP_MAX);

    // Strobe/data register and saturating gap counter restarted by every payload byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uart_txd_strobe <= 1'b0;
            uart_txd        <= 8'h00;
            gap_cnt         <= '0;
        end else begin
            uart_txd_strobe <= send && free;
            if (send && free) begin
                uart_txd <= data;
            end
            if (send && free && payload) begin
                gap_cnt <= '0;
            end else if (gap_cnt < GAP_MAX) begin
                gap_cnt <= gap_cnt + GW'(1);
            end
        end
    end

endmodule

// File: rtl/user_command_issuer.sv
// Host-side initiator for the '!'-framed serial command protocol.
// Optional rx-wait timeout enabled by defining USER_CMD_TIMEOUT_EN.
module user_command_issuer
    import user_cmd_pkg::*;
#(
    parameter int unsigned VERSION_LEN    = 8,
    parameter int unsigned WR_GAP_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [23:0] req_len,
    input  logic [31:0] req_addr,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic [1:0]  error,
    output logic [7:0]  uart_txd,
    output logic        uart_txd_strobe,
    input  logic        uart_txd_ready,
    input  logic [7:0]  uart_rxd,
    input  logic        uart_rxd_strobe
);

    state_t      state;
    logic [7:0]  cmd;
    logic [23:0] len;
    logic [31:0] addr;
    logic [23:0] remaining;

    logic        send_c;
    logic        payload_c;
    logic [7:0]  tx_byte_c;
    logic        free;
    logic        gap_ok_c;
    logic        timeout_hit_c;

    user_cmd_tx_pacer #(
        .WR_GAP_CYCLES(WR_GAP_CYCLES)
    ) u_pacer (
        .clk            (clk),
        .reset_n        (reset_n),
        .send           (send_c),
        .payload        (payload_c),
        .data           (tx_byte_c),
        .uart_txd_ready (uart_txd_ready),
        .uart_txd       (uart_txd),
        .uart_txd_strobe(uart_txd_strobe),
        .free           (free),
        .gap_ok_c       (gap_ok_c)
    );

`ifdef USER_CMD_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt;
    logic            waiting_c;

    assign waiting_c     = (state == ST_ECHO) || (state == ST_RDATA) || (state == ST_WACK);
    assign timeout_hit_c = waiting_c && !uart_rxd_strobe && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Counts clocks since the last rx byte while a response is outstanding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (!waiting_c || uart_rxd_strobe) begin
            to_cnt <= '0;
        end else if (!timeout_hit_c) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign timeout_hit_c = 1'b0;
`endif

    // Selects the byte offered to the tx slot; the header goes out straight from IDLE when possible.
    always_comb begin
        send_c    = 1'b0;
        payload_c = 1'b0;
        tx_byte_c = 8'h00;
        case (state)
            ST_IDLE:  begin send_c = req_valid && req_ready && free; tx_byte_c = CMD_HDR; end
            ST_HDR:   begin send_c = free; tx_byte_c = CMD_HDR;      end
            ST_CMD:   begin send_c = free; tx_byte_c = cmd;          end
            ST_LEN2:  begin send_c = free; tx_byte_c = len[23:16];   end
            ST_LEN1:  begin send_c = free; tx_byte_c = len[15:8];    end
            ST_LEN0:  begin send_c = free; tx_byte_c = len[7:0];     end
            ST_ADDR3: begin send_c = free; tx_byte_c = addr[31:24];  end
            ST_ADDR2: begin send_c = free; tx_byte_c = addr[23:16];  end
            ST_ADDR1: begin send_c = free; tx_byte_c = addr[15:8];   end
            ST_ADDR0: begin send_c = free; tx_byte_c = addr[7:0];    end
            ST_WDATA: begin
                send_c    = (remaining != 24'd0) && wr_valid && free && gap_ok_c;
                payload_c = 1'b1;
                tx_byte_c = wr_data;
            end
            default: ;
        endcase
    end

    // Transaction sequencer with registered handshake, read-data and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cmd       <= 8'h00;
            len       <= 24'd0;
            addr      <= 32'd0;
            remaining <= 24'd0;
            req_ready <= 1'b1;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
            wr_ready  <= 1'b0;
            done      <= 1'b0;
            error     <= ERR_NONE;
        end else begin
            rd_valid <= 1'b0;
            wr_ready <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        cmd       <= req_cmd;
                        len       <= req_len;
                        addr      <= req_addr;
                        error     <= ERR_NONE;
                        req_ready <= 1'b0;
                        state     <= send_c ? ST_CMD : ST_HDR;
                    end
                end
                ST_HDR:   if (send_c) state <= ST_CMD;
                ST_CMD:   if (send_c) state <= ST_ECHO;
                ST_ECHO: begin
                    if (uart_rxd_strobe) begin
                        if (uart_rxd != cmd) begin
                            error <= ERR_ECHO;
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else if (cmd == CMD_VERSION) begin
                            remaining <= 24'(VERSION_LEN);
                            state     <= ST_RDATA;
                        end else begin
                            state <= ST_LEN2;
                        end
                    end else if (timeout_hit_c) begin
                        error <= ERR_TIMEOUT;
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end
                end
                ST_LEN2:  if (send_c) state <= ST_LEN1;
                ST_LEN1:  if (send_c) state <= ST_LEN0;
                ST_LEN0:  if (send_c) state <= ST_ADDR3;
                ST_ADDR3: if (send_c) state <= ST_ADDR2;
                ST_ADDR2: if (send_c) state <= ST_ADDR1;
                ST_ADDR1: if (send_c) state <= ST_ADDR0;
                ST_ADDR0: begin
                    if (send_c) begin
                        remaining <= len;
                        if (cmd == CMD_WR) begin
                            state <= ST_WDATA;
                        end else if (len == 24'd0) begin
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            state <= ST_RDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (remaining == 24'd0) begin
                        state <= ST_WACK;
                    end else if (send_c) begin
                        wr_ready  <= 1'b1;
                        remaining <= remaining - 24'd1;
                    end
                end
                ST_WACK: begin
                    if (uart_rxd_strobe) begin
                        if (uart_rxd != CMD_WR) begin
                            error <= ERR_WACK;
                        end
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end else if (timeout_hit_c) begin
                        error <= ERR_TIMEOUT;
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end
                end
                ST_RDATA: begin
                    if (remaining == 24'd0) begin
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end else if (uart_rxd_strobe) begin
                        rd_data   <= uart_rxd;
                        rd_valid  <= 1'b1;
                        remaining <= remaining - 24'd1;
                        if (remaining == 24'd1) begin
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end
                    end else if (timeout_hit_c) begin
                        error <= ERR_TIMEOUT;
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_user_command_issuer.sv
// Scoreboard bench for user_command_issuer; drives a scripted peer on the UART side.
module tb_user_command_issuer;

    localparam int unsigned T_OUT = 100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_cmd = 8'h00;
    logic [23:0] req_len = 24'd0;
    logic [31:0] req_addr = 32'd0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic [1:0]  error;
    logic [7:0]  uart_txd;
    logic        uart_txd_strobe;
    logic        uart_txd_ready = 1'b1;
    logic [7:0]  uart_rxd = 8'h00;
    logic        uart_rxd_strobe = 1'b0;

    always #5 clk = ~clk;

    user_command_issuer #(
        .VERSION_LEN   (8),
        .WR_GAP_CYCLES (16),
        .TIMEOUT_CYCLES(T_OUT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_cmd        (req_cmd),
        .req_len        (req_len),
        .req_addr       (req_addr),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .done           (done),
        .error          (error),
        .uart_txd       (uart_txd),
        .uart_txd_strobe(uart_txd_strobe),
        .uart_txd_ready (uart_txd_ready),
        .uart_rxd       (uart_rxd),
        .uart_rxd_strobe(uart_rxd_strobe)
    );

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_rd[$];
    logic [1:0]  exp_err[$];
    int          tx_count = 0;
    int          rd_count = 0;
    int          done_count = 0;
    int          wr_ready_count = 0;
    int unsigned last_done_cyc = 0;
    int unsigned last_wr_cyc = 0;
    int unsigned last_rx_cyc = 0;
    bit          wr_seen = 1'b0;
    logic        prev_strobe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a tx byte, read byte or completion.
    always @(negedge clk) begin
        if (reset_n) begin
            if (uart_txd_strobe) begin
                tx_count++;
                check("tx_back_to_back", int'(prev_strobe), 0);
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got 0x%02h, expected no byte", uart_txd);
                end else begin
                    check("tx_byte", int'(uart_txd), int'(exp_tx.pop_front()));
                end
            end
            if (rd_valid) begin
                rd_count++;
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got 0x%02h, expected no byte", rd_data);
                end else begin
                    check("rd_byte", int'(rd_data), int'(exp_rd.pop_front()));
                end
            end
            if (wr_ready) begin
                wr_ready_count++;
                if (wr_seen) begin
                    checks++;
                    if (cyc - last_wr_cyc < 16) begin
                        errors++;
                        $display("FAIL wr_gap: spacing %0d cycles, expected >= 16", cyc - last_wr_cyc);
                    end
                end
                wr_seen     = 1'b1;
                last_wr_cyc = cyc;
            end
            if (done) begin
                done_count++;
                last_done_cyc = cyc;
                wr_seen       = 1'b0;
                if (exp_err.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got error=%0d, expected no done", error);
                end else begin
                    check("done_error", int'(error), int'(exp_err.pop_front()));
                end
            end
        end
        prev_strobe = uart_txd_strobe;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        uart_rxd        = b;
        uart_rxd_strobe = 1'b1;
        last_rx_cyc     = cyc;
        tick(1);
        uart_rxd_strobe = 1'b0;
        tick(1);
    endtask

    task automatic issue(input logic [7:0] c, input logic [23:0] l, input logic [31:0] a);
        int k = 0;
        while (!req_ready && k < 200) begin
            tick(1);
            k++;
        end
        check("req_ready_before_issue", int'(req_ready), 1);
        req_cmd   = c;
        req_len   = l;
        req_addr  = a;
        req_valid = 1'b1;
        tick(1);
        req_valid = 1'b0;
    endtask

    task automatic push_len_addr(input logic [23:0] l, input logic [31:0] a);
        exp_tx.push_back(l[23:16]);
        exp_tx.push_back(l[15:8]);
        exp_tx.push_back(l[7:0]);
        exp_tx.push_back(a[31:24]);
        exp_tx.push_back(a[23:16]);
        exp_tx.push_back(a[15:8]);
        exp_tx.push_back(a[7:0]);
    endtask

    task automatic wait_tx(input int n, input string name);
        int k = 0;
        while (tx_count < n && k < 2000) begin
            tick(1);
            k++;
        end
        check(name, tx_count, n);
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int k = 0;
        while (done_count < n && k < budget) begin
            tick(1);
            k++;
        end
        check(name, done_count, n);
    endtask

    task automatic wait_wr_ready(input string name);
        int k = 0;
        while (!wr_ready && k < 300) begin
            tick(1);
            k++;
        end
        check(name, int'(wr_ready), 1);
        tick(1);
    endtask

    initial begin
        int base;
        int tgt;
        int wbase;

        tick(3);
        check("rst_txd_strobe", int'(uart_txd_strobe), 0);
        check("rst_txd", int'(uart_txd), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_wr_ready", int'(wr_ready), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        check("rst_req_ready", int'(req_ready), 1);
        reset_n = 1'b1;
        tick(2);

        // Rx traffic while idle must be ignored.
        send_rx(8'h52);
        tick(3);
        check("idle_rx_no_rd", rd_count, 0);
        check("idle_rx_no_done", done_count, 0);

        // V request with the UART briefly busy.
        base = tx_count;
        tgt  = done_count + 1;
        uart_txd_ready = 1'b0;
        exp_tx.push_back(8'h21);
        exp_tx.push_back(8'h56);
        issue(8'h56, 24'd0, 32'd0);
        tick(5);
        check("v_hold_when_busy", tx_count, base);
        uart_txd_ready = 1'b1;
        wait_tx(base + 2, "v_frame");
        for (int i = 0; i < 8; i++) exp_rd.push_back(8'h31);
        exp_err.push_back(2'd0);
        send_rx(8'h56);
        for (int i = 0; i < 8; i++) send_rx(8'h31);
        wait_done(tgt, 200, "v_done");
        check("v_rd_count", rd_count, 8);
        tick(1);
        check("v_req_ready_after", int'(req_ready), 1);

        // R len=3 addr=0x1000.
        base = tx_count;
        tgt  = done_count + 1;
        exp_tx.push_back(8'h21);
        exp_tx.push_back(8'h52);
        push_len_addr(24'd3, 32'h0000_1000);
        issue(8'h52, 24'd3, 32'h0000_1000);
        wait_tx(base + 2, "r_hdr");
        send_rx(8'h52);
        wait_tx(base + 9, "r_frame");
        exp_rd.push_back(8'hAA);
        exp_rd.push_back(8'hBB);
        exp_rd.push_back(8'hCC);
        exp_err.push_back(2'd0);
        send_rx(8'hAA);
        send_rx(8'hBB);
        send_rx(8'hCC);
        wait_done(tgt, 200, "r_done");
        check("r_done_latency", int'(last_done_cyc - last_rx_cyc), 1);

        // W len=2 with wr_valid held high throughout.
        base  = tx_count;
        tgt   = done_count + 1;
        wbase = wr_ready_count;
        exp_tx.push_back(8'h21);
        exp_tx.push_back(8'h57);
        push_len_addr(24'd2, 32'h0000_0020);
        exp_tx.push_back(8'h11);
        exp_tx.push_back(8'h22);
        wr_data  = 8'h11;
        wr_valid = 1'b1;
        issue(8'h57, 24'd2, 32'h0000_0020);
        wait_tx(base + 2, "w_hdr");
        send_rx(8'h57);
        wait_wr_ready("w_ready_0");
        wr_data = 8'h22;
        wait_wr_ready("w_ready_1");
        wr_data = 8'h33;
        wait_tx(base + 11, "w_frame");
        tick(40);
        check("w_ready_pulses", wr_ready_count - wbase, 2);
        exp_err.push_back(2'd0);
        send_rx(8'h57);
        wait_done(tgt, 200, "w_done");
        wr_valid = 1'b0;

        // Unknown command answered with '?': echo error, no len/addr.
        base = tx_count;
        tgt  = done_count + 1;
        exp_tx.push_back(8'h21);
        exp_tx.push_back(8'h58);
        issue(8'h58, 24'd5, 32'h1234_5678);
        wait_tx(base + 2, "x_hdr");
        exp_err.push_back(2'd1);
        send_rx(8'h3F);
        wait_done(tgt, 200, "x_done");
        tick(10);
        check("x_no_len_addr", tx_count, base + 2);

        // W len=0 goes straight to ack; a wrong ack byte reports error 2.
        base  = tx_count;
        tgt   = done_count + 1;
        wbase = wr_ready_count;
        exp_tx.push_back(8'h21);
        exp_tx.push_back(8'h57);
        push_len_addr(24'd0, 32'h0000_0040);
        wr_valid = 1'b1;
        issue(8'h57, 24'd0, 32'h0000_0040);
        wait_tx(base + 2, "w0_hdr");
        send_rx(8'h57);
        wait_tx(base + 9, "w0_frame");
        tick(20);
        exp_err.push_back(2'd2);
        send_rx(8'h5A);
        wait_done(tgt, 200, "w0_done");
        wr_valid = 1'b0;
        check("w0_no_payload", wr_ready_count - wbase, 0);

        // R len=0 completes right after the address bytes.
        base = tx_count;
        tgt  = done_count + 1;
        exp_tx.push_back(8'h21);
        exp_tx.push_back(8'h52);
        push_len_addr(24'd0, 32'h0000_0080);
        exp_err.push_back(2'd0);
        issue(8'h52, 24'd0, 32'h0000_0080);
        wait_tx(base + 2, "r0_hdr");
        send_rx(8'h52);
        wait_done(tgt, 200, "r0_done");
        check("r0_frame_len", tx_count, base + 9);

        // R len=4 stalls after one data byte.
        base = tx_count;
        tgt  = done_count + 1;
        exp_tx.push_back(8'h21);
        exp_tx.push_back(8'h52);
        push_len_addr(24'd4, 32'h0000_0000);
        issue(8'h52, 24'd4, 32'h0000_0000);
        wait_tx(base + 2, "stall_hdr");
        send_rx(8'h52);
        wait_tx(base + 9, "stall_frame");
        exp_rd.push_back(8'h44);
        send_rx(8'h44);
`ifdef USER_CMD_TIMEOUT_EN
        exp_err.push_back(2'd3);
        wait_done(tgt, 300, "timeout_done");
        check("timeout_latency", int'(last_done_cyc - last_rx_cyc), T_OUT + 1);
`else
        tick(300);
        check("no_timeout_stays", done_count, tgt - 1);
        check("no_timeout_busy", int'(req_ready), 0);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
`endif

        // Reset while ADDR1 is about to send.
        base = tx_count;
        exp_tx.push_back(8'h21);
        exp_tx.push_back(8'h52);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h01);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00);
        issue(8'h52, 24'd1, 32'h0000_0000);
        wait_tx(base + 2, "rst_hdr");
        send_rx(8'h52);
        wait_tx(base + 7, "rst_partial");
        reset_n = 1'b0;
        #1;
        check("midrst_strobe", int'(uart_txd_strobe), 0);
        check("midrst_req_ready", int'(req_ready), 1);
        check("midrst_error", int'(error), 0);
        tick(2);
        check("midrst_no_more_tx", tx_count, base + 7);
        reset_n = 1'b1;
        tick(2);

        // Fresh V request after reset.
        base = tx_count;
        tgt  = done_count + 1;
        exp_tx.push_back(8'h21);
        exp_tx.push_back(8'h56);
        issue(8'h56, 24'd0, 32'd0);
        wait_tx(base + 2, "v2_frame");
        for (int i = 0; i < 8; i++) exp_rd.push_back(8'(8'h10 + i));
        exp_err.push_back(2'd0);
        send_rx(8'h56);
        for (int i = 0; i < 8; i++) send_rx(8'(8'h10 + i));
        wait_done(tgt, 200, "v2_done");
        tick(5);

        check("end_exp_tx_empty", exp_tx.size(), 0);
        check("end_exp_rd_empty", exp_rd.size(), 0);
        check("end_exp_err_empty", exp_err.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
